// File: rtl/mouse_bus_poller.sv
// Bus initiator that services the mouse peripheral's interrupt: it reads status, X and Y
// over the shared bus, acknowledges the interrupt and publishes the packet with a valid strobe.
module mouse_bus_poller #(
   parameter logic [7:0] BaseAddr = 8'hA0,
   parameter logic [7:0] IdleAddr = 8'hFF
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   output logic       BUS_REQ,
   input  logic       BUS_GNT,
   output logic [7:0] BUS_ADDR,
   input  logic [7:0] BUS_DATA,
   output logic       BUS_WE,
   input  logic       BUS_INTERRUPT_RAISE,
   output logic       BUS_INTERRUPT_ACK,
   output logic [7:0] MOUSE_STATUS,
   output logic [7:0] MOUSE_X,
   output logic [7:0] MOUSE_Y,
   output logic       PACKET_VALID,
   output logic [7:0] PACKET_COUNT
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      R_ADDR = 3'd2,
      R_CAP  = 3'd3,
      ACK    = 3'd4,
      GAP    = 3'd5
   } state_t;

   state_t     state;
   logic [1:0] index;
   logic [7:0] shadow_status;
   logic [7:0] shadow_x;
   logic [7:0] shadow_y;

   // Read-only initiator: the write enable never leaves zero.
   assign BUS_WE = 1'b0;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state             <= IDLE;
         index             <= 2'd0;
         BUS_REQ           <= 1'b0;
         BUS_ADDR          <= IdleAddr;
         BUS_INTERRUPT_ACK <= 1'b0;
         PACKET_VALID      <= 1'b0;
         MOUSE_STATUS      <= 8'd0;
         MOUSE_X           <= 8'd0;
         MOUSE_Y           <= 8'd0;
         PACKET_COUNT      <= 8'd0;
         shadow_status     <= 8'd0;
         shadow_x          <= 8'd0;
         shadow_y          <= 8'd0;
      end else begin
         BUS_INTERRUPT_ACK <= 1'b0;
         PACKET_VALID      <= 1'b0;
         case (state)
            IDLE: begin
               BUS_REQ  <= 1'b0;
               BUS_ADDR <= IdleAddr;
               if (ENABLE && BUS_INTERRUPT_RAISE) begin
                  state   <= REQ;
                  index   <= 2'd0;
                  BUS_REQ <= 1'b1;
               end
            end
            REQ: begin
               if (BUS_GNT) begin
                  state    <= R_ADDR;
                  BUS_ADDR <= BaseAddr + {6'd0, index};
               end
            end
            R_ADDR: begin
               if (!BUS_GNT) begin
                  state    <= REQ;
                  BUS_ADDR <= IdleAddr;
               end else begin
                  state <= R_CAP;
               end
            end
            R_CAP: begin
               // Grant lost: the current byte is abandoned and re-read after re-grant.
               if (!BUS_GNT) begin
                  state    <= REQ;
                  BUS_ADDR <= IdleAddr;
               end else begin
                  case (index)
                     2'd0:    shadow_status <= BUS_DATA;
                     2'd1:    shadow_x      <= BUS_DATA;
                     default: shadow_y      <= BUS_DATA;
                  endcase
                  if (index < 2'd2) begin
                     index    <= index + 2'd1;
                     BUS_ADDR <= BaseAddr + {6'd0, index} + 8'd1;
                     state    <= R_ADDR;
                  end else begin
                     state             <= ACK;
                     BUS_ADDR          <= IdleAddr;
                     BUS_REQ           <= 1'b0;
                     BUS_INTERRUPT_ACK <= 1'b1;
                  end
               end
            end
            ACK: begin
               MOUSE_STATUS <= shadow_status;
               MOUSE_X      <= shadow_x;
               MOUSE_Y      <= shadow_y;
               PACKET_VALID <= 1'b1;
               PACKET_COUNT <= PACKET_COUNT + 8'd1;
               state        <= GAP;
            end
            GAP: begin
               // Lets the peripheral's cleared interrupt become visible before IDLE looks at it.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mouse_bus_poller.sv
// Self-checking bench for mouse_bus_poller: a registered peripheral model, a per-cycle
// monitor with an expected-packet queue, and one task per scenario.
module tb_mouse_bus_poller;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       ENABLE = 1'b1;
   logic       BUS_REQ;
   logic       BUS_GNT = 1'b1;
   logic [7:0] BUS_ADDR;
   logic [7:0] BUS_DATA = 8'h00;
   logic       BUS_WE;
   logic       BUS_INTERRUPT_RAISE = 1'b0;
   logic       BUS_INTERRUPT_ACK;
   logic [7:0] MOUSE_STATUS;
   logic [7:0] MOUSE_X;
   logic [7:0] MOUSE_Y;
   logic       PACKET_VALID;
   logic [7:0] PACKET_COUNT;

   mouse_bus_poller dut (
      .CLK                 (CLK),
      .RESET               (RESET),
      .ENABLE              (ENABLE),
      .BUS_REQ             (BUS_REQ),
      .BUS_GNT             (BUS_GNT),
      .BUS_ADDR            (BUS_ADDR),
      .BUS_DATA            (BUS_DATA),
      .BUS_WE              (BUS_WE),
      .BUS_INTERRUPT_RAISE (BUS_INTERRUPT_RAISE),
      .BUS_INTERRUPT_ACK   (BUS_INTERRUPT_ACK),
      .MOUSE_STATUS        (MOUSE_STATUS),
      .MOUSE_X             (MOUSE_X),
      .MOUSE_Y             (MOUSE_Y),
      .PACKET_VALID        (PACKET_VALID),
      .PACKET_COUNT        (PACKET_COUNT)
   );

   // Clock and reset
   always #5 CLK = ~CLK;

   // Peripheral model: registered data one edge after the address, set-priority interrupt flag.
   logic [7:0] mem [3];
   logic       raise_evt = 1'b0;

   always @(posedge CLK) begin
      if (raise_evt) BUS_INTERRUPT_RAISE <= 1'b1;
      else if (BUS_INTERRUPT_ACK) BUS_INTERRUPT_RAISE <= 1'b0;
      case (BUS_ADDR)
         8'hA0:   BUS_DATA <= mem[0];
         8'hA1:   BUS_DATA <= mem[1];
         8'hA2:   BUS_DATA <= mem[2];
         default: BUS_DATA <= 8'h00;
      endcase
   end

   // Scoreboard state
   int          checks = 0;
   int          fails = 0;
   logic [23:0] exp_q[$];
   logic [7:0]  exp_count = 8'd0;
   int          ack_cnt = 0;
   int          valid_cnt = 0;
   logic        prev_ack = 1'b0;
   logic [23:0] prev_out = 24'd0;

   // Advance one cycle and run the per-cycle monitor, sampling 1 time unit after the edge.
   task automatic tick();
      logic [23:0] exp_pkt;
      logic [23:0] obs_pkt;
      @(posedge CLK);
      #1;
      obs_pkt = {MOUSE_STATUS, MOUSE_X, MOUSE_Y};
      checks++;
      if (BUS_WE !== 1'b0) begin
         fails++;
         $display("FAIL we_zero: BUS_WE=%b required 0 at %0t", BUS_WE, $time);
      end
      checks++;
      if (BUS_ADDR !== 8'hFF && BUS_ADDR !== 8'hA0 && BUS_ADDR !== 8'hA1 && BUS_ADDR !== 8'hA2) begin
         fails++;
         $display("FAIL addr_legal: BUS_ADDR=%h required FF or A0..A2 at %0t", BUS_ADDR, $time);
      end
      if (BUS_INTERRUPT_ACK === 1'b1) ack_cnt++;
      if (RESET) begin
         exp_count = 8'd0;
      end else if (PACKET_VALID === 1'b1) begin
         valid_cnt++;
         exp_count = exp_count + 8'd1;
         checks++;
         if (prev_ack !== 1'b1) begin
            fails++;
            $display("FAIL valid_after_ack: previous ACK=%b required 1 at %0t", prev_ack, $time);
         end
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL packet_unexpected: got %h with empty expected queue at %0t", obs_pkt, $time);
         end else begin
            exp_pkt = exp_q.pop_front();
            if (obs_pkt !== exp_pkt) begin
               fails++;
               $display("FAIL packet_data: got %h required %h at %0t", obs_pkt, exp_pkt, $time);
            end
         end
         checks++;
         if (PACKET_COUNT !== exp_count) begin
            fails++;
            $display("FAIL packet_count: got %0d required %0d at %0t", PACKET_COUNT, exp_count, $time);
         end
      end else begin
         checks++;
         if (obs_pkt !== prev_out) begin
            fails++;
            $display("FAIL outputs_stable: got %h required %h without valid at %0t", obs_pkt, prev_out, $time);
         end
      end
      prev_ack = BUS_INTERRUPT_ACK;
      prev_out = obs_pkt;
   endtask

   // Driver tasks
   task automatic set_mem(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
      mem[0] = s;
      mem[1] = x;
      mem[2] = y;
   endtask

   task automatic pulse_event(input bit push);
      if (push) exp_q.push_back({mem[0], mem[1], mem[2]});
      raise_evt = 1'b1;
      tick();
      raise_evt = 1'b0;
   endtask

   task automatic wait_packets(input int n, input int budget);
      int target;
      int i;
      target = valid_cnt + n;
      i = 0;
      while (valid_cnt < target && i < budget) begin
         tick();
         i++;
      end
      checks++;
      if (valid_cnt < target) begin
         fails++;
         $display("FAIL packet_timeout: got %0d packets required %0d within %0d cycles", valid_cnt, target, budget);
      end
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      repeat (3) tick();
      RESET = 1'b0;
      tick();
   endtask

   // Scenarios
   task automatic test_reset();
      do_reset();
      checks++;
      if (BUS_ADDR !== 8'hFF || BUS_REQ !== 1'b0 || BUS_INTERRUPT_ACK !== 1'b0 || PACKET_VALID !== 1'b0) begin
         fails++;
         $display("FAIL reset_bus: addr=%h req=%b ack=%b valid=%b required FF 0 0 0", BUS_ADDR, BUS_REQ, BUS_INTERRUPT_ACK, PACKET_VALID);
      end
      checks++;
      if ({MOUSE_STATUS, MOUSE_X, MOUSE_Y, PACKET_COUNT} !== 32'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h %h %h %h required all 0", MOUSE_STATUS, MOUSE_X, MOUSE_Y, PACKET_COUNT);
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp_addr [9];
      int a0;
      exp_addr = '{8'hFF, 8'hA0, 8'hA0, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hFF, 8'hFF};
      set_mem(8'h08, 8'h05, 8'hFB);
      BUS_GNT = 1'b1;
      a0 = ack_cnt;
      pulse_event(1'b1);
      for (int k = 0; k < 9; k++) begin
         tick();
         checks++;
         if (BUS_ADDR !== exp_addr[k] || BUS_REQ !== (k < 7) || BUS_INTERRUPT_ACK !== (k == 7) || PACKET_VALID !== (k == 8)) begin
            fails++;
            $display("FAIL basic_cycle%0d: addr=%h req=%b ack=%b valid=%b required %h %b %b %b", k, BUS_ADDR, BUS_REQ,
                     BUS_INTERRUPT_ACK, PACKET_VALID, exp_addr[k], k < 7, k == 7, k == 8);
         end
      end
      checks++;
      if ({MOUSE_STATUS, MOUSE_X, MOUSE_Y, PACKET_COUNT} !== 32'h0805FB01 || ack_cnt - a0 != 1) begin
         fails++;
         $display("FAIL basic_packet: got %h %h %h cnt %0d acks %0d required 08 05 FB cnt 1 acks 1", MOUSE_STATUS,
                  MOUSE_X, MOUSE_Y, PACKET_COUNT, ack_cnt - a0);
      end
   endtask

   task automatic test_grant_wait();
      int a0;
      set_mem(8'h1C, 8'h7F, 8'h80);
      BUS_GNT = 1'b0;
      a0 = ack_cnt;
      pulse_event(1'b1);
      tick();
      repeat (5) begin
         tick();
         checks++;
         if (BUS_REQ !== 1'b1 || BUS_ADDR !== 8'hFF || BUS_INTERRUPT_ACK !== 1'b0) begin
            fails++;
            $display("FAIL grant_wait_hold: req=%b addr=%h ack=%b required 1 FF 0", BUS_REQ, BUS_ADDR, BUS_INTERRUPT_ACK);
         end
      end
      BUS_GNT = 1'b1;
      wait_packets(1, 20);
      checks++;
      if (MOUSE_X !== 8'h7F || ack_cnt - a0 != 1) begin
         fails++;
         $display("FAIL grant_wait_done: x=%h acks=%0d required 7F 1", MOUSE_X, ack_cnt - a0);
      end
   endtask

   task automatic test_grant_loss();
      int a0;
      set_mem(8'h09, 8'h11, 8'h33);
      a0 = ack_cnt;
      exp_q.push_back({8'h09, 8'h5A, 8'h33});
      pulse_event(1'b0);
      repeat (5) tick();
      checks++;
      if (BUS_ADDR !== 8'hA1) begin
         fails++;
         $display("FAIL loss_setup: addr=%h required A1", BUS_ADDR);
      end
      BUS_GNT = 1'b0;
      mem[1] = 8'h5A;
      tick();
      checks++;
      if (BUS_ADDR !== 8'hFF || BUS_REQ !== 1'b1) begin
         fails++;
         $display("FAIL loss_release: addr=%h req=%b required FF 1", BUS_ADDR, BUS_REQ);
      end
      tick();
      BUS_GNT = 1'b1;
      tick();
      checks++;
      if (BUS_ADDR !== 8'hA1) begin
         fails++;
         $display("FAIL loss_reread: addr=%h required A1", BUS_ADDR);
      end
      wait_packets(1, 20);
      checks++;
      if (MOUSE_X !== 8'h5A || ack_cnt - a0 != 1) begin
         fails++;
         $display("FAIL loss_done: x=%h acks=%0d required 5A 1", MOUSE_X, ack_cnt - a0);
      end
   endtask

   task automatic test_back_to_back();
      int a0;
      int i;
      set_mem(8'h42, 8'h01, 8'hFE);
      a0 = ack_cnt;
      pulse_event(1'b1);
      i = 0;
      while (BUS_INTERRUPT_ACK !== 1'b1 && i < 20) begin
         tick();
         i++;
      end
      checks++;
      if (BUS_INTERRUPT_ACK !== 1'b1) begin
         fails++;
         $display("FAIL b2b_ack_timeout: ack=%b required 1 within 20 cycles", BUS_INTERRUPT_ACK);
      end
      exp_q.push_back({mem[0], mem[1], mem[2]});
      raise_evt = 1'b1;
      tick();
      raise_evt = 1'b0;
      wait_packets(1, 30);
      checks++;
      if (PACKET_COUNT !== 8'd5 || ack_cnt - a0 != 2) begin
         fails++;
         $display("FAIL b2b_count: count=%0d acks=%0d required 5 2", PACKET_COUNT, ack_cnt - a0);
      end
   endtask

   task automatic test_reset_mid();
      int a0;
      int i;
      set_mem(8'h77, 8'h88, 8'h99);
      a0 = ack_cnt;
      pulse_event(1'b1);
      i = 0;
      while (BUS_ADDR !== 8'hA2 && i < 20) begin
         tick();
         i++;
      end
      checks++;
      if (BUS_ADDR !== 8'hA2) begin
         fails++;
         $display("FAIL rst_mid_setup: addr=%h required A2 within 20 cycles", BUS_ADDR);
      end
      RESET = 1'b1;
      tick();
      checks++;
      if ({MOUSE_STATUS, MOUSE_X, MOUSE_Y, PACKET_COUNT} !== 32'd0 || BUS_REQ !== 1'b0 || BUS_ADDR !== 8'hFF ||
          ack_cnt != a0) begin
         fails++;
         $display("FAIL rst_mid_state: out=%h%h%h cnt=%0d req=%b addr=%h acks=%0d required 0 0 0 FF 0", MOUSE_STATUS,
                  MOUSE_X, MOUSE_Y, PACKET_COUNT, BUS_REQ, BUS_ADDR, ack_cnt - a0);
      end
      RESET = 1'b0;
      wait_packets(1, 30);
      checks++;
      if (MOUSE_STATUS !== 8'h77 || PACKET_COUNT !== 8'd1 || ack_cnt - a0 != 1) begin
         fails++;
         $display("FAIL rst_mid_resume: status=%h count=%0d acks=%0d required 77 1 1", MOUSE_STATUS, PACKET_COUNT, ack_cnt - a0);
      end
   endtask

   task automatic test_enable();
      int a0;
      int i;
      set_mem(8'h3C, 8'hC3, 8'h5A);
      a0 = ack_cnt;
      ENABLE = 1'b0;
      pulse_event(1'b1);
      repeat (40) begin
         tick();
         checks++;
         if (BUS_REQ !== 1'b0) begin
            fails++;
            $display("FAIL enable_block: req=%b required 0", BUS_REQ);
         end
      end
      ENABLE = 1'b1;
      i = 0;
      while (BUS_REQ !== 1'b1 && i < 5) begin
         tick();
         i++;
      end
      ENABLE = 1'b0;
      wait_packets(1, 30);
      ENABLE = 1'b1;
      checks++;
      if (MOUSE_Y !== 8'h5A || ack_cnt - a0 != 1) begin
         fails++;
         $display("FAIL enable_inflight: y=%h acks=%0d required 5A 1", MOUSE_Y, ack_cnt - a0);
      end
   endtask

   task automatic test_wrap();
      int need;
      need = 256 - int'(exp_count);
      for (int i = 0; i < need; i++) begin
         set_mem(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         BUS_GNT = ($urandom_range(0, 3) != 0);
         pulse_event(1'b1);
         BUS_GNT = 1'b1;
         wait_packets(1, 40);
      end
      checks++;
      if (PACKET_COUNT !== 8'd0) begin
         fails++;
         $display("FAIL count_wrap: count=%0d required 0", PACKET_COUNT);
      end
   endtask

   initial begin
      set_mem(8'h00, 8'h00, 8'h00);
      test_reset();
      test_basic();
      test_grant_wait();
      test_grant_loss();
      test_back_to_back();
      test_reset_mid();
      test_enable();
      test_wrap();
      repeat (3) tick();
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL leftover_packets: %0d expected packets never delivered", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
